scarv_cop_malu_issue: RTL and testbench

- Issue/writeback sequencer that drives the multi-precision ALU (MALU) from the coprocessor decode stage.
- Accepts one decoded MP instruction and fetches its CPR operands, honouring the MALU's rdm-in-rs request.
- Holds malu_ivalid asserted until malu_idone, then steers each writeback beat into the destination CPR pair (lo, then hi).
- Comparison results return to the CPU as a GPR write.

---
 rtl/scarv_cop_malu_issue.sv | 191 +++++++++++++++++++
 tb/tb_scarv_cop_malu_issue.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/scarv_cop_malu_issue.sv
// Issue/writeback sequencer between the coprocessor decode stage and the MALU.
// Define SCARV_COP_MALU_ISSUE_WATCHDOG_EN to abort instructions the MALU never completes.
module scarv_cop_malu_issue #(
  parameter int unsigned CPR_AW     = 4,
  parameter int unsigned WDOG_LIMIT = 7
) (
  input  logic              g_clk,
  input  logic              g_resetn,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [2:0]        id_class,
  input  logic [3:0]        id_subclass,
  input  logic [31:0]       id_imm,
  input  logic [CPR_AW-1:0] id_crs1,
  input  logic [CPR_AW-1:0] id_crs2,
  input  logic [CPR_AW-1:0] id_crs3,
  input  logic [CPR_AW-2:0] id_crdm,
  input  logic [31:0]       id_gpr_rs1,
  output logic [CPR_AW-1:0] cpr_ra1,
  output logic [CPR_AW-1:0] cpr_ra2,
  output logic [CPR_AW-1:0] cpr_ra3,
  input  logic [31:0]       cpr_rd1,
  input  logic [31:0]       cpr_rd2,
  input  logic [31:0]       cpr_rd3,
  output logic              malu_ivalid,
  input  logic              malu_idone,
  input  logic              malu_rdm_in_rs,
  output logic [31:0]       malu_rs1,
  output logic [31:0]       malu_rs2,
  output logic [31:0]       malu_rs3,
  output logic [31:0]       malu_gpr_rs1,
  output logic [31:0]       malu_imm,
  output logic [2:0]        malu_class,
  output logic [3:0]        malu_subclass,
  input  logic [3:0]        malu_cpr_rd_ben,
  input  logic [31:0]       malu_cpr_rd_wdata,
  output logic              cpr_wen,
  output logic [CPR_AW-1:0] cpr_waddr,
  output logic [3:0]        cpr_wben,
  output logic [31:0]       cpr_wdata,
  output logic              gpr_wen,
  output logic [31:0]       gpr_wdata,
  output logic              insn_done,
  output logic              insn_err
);

  localparam logic [3:0] SCLASS_EQU_MP = 4'b0001;
  localparam logic [3:0] SCLASS_LTU_MP = 4'b0010;
  localparam logic [3:0] SCLASS_GTU_MP = 4'b0011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [3:0]        r_subclass;
  logic [2:0]        r_class;
  logic [31:0]       r_imm;
  logic [CPR_AW-1:0] r_crs1, r_crs2, r_crs3;
  logic [CPR_AW-2:0] r_crdm;
  logic [31:0]       r_gpr_rs1;
  logic              wb_cnt;
  logic              gpr_flag;
  logic [31:0]       r_gpr_wdata;

  logic busy, accept, wb_fire, is_cmp, wdog_abort;

  assign busy    = (state == BUSY);
  assign accept  = (state == IDLE) && id_valid;
  assign wb_fire = busy && (|malu_cpr_rd_ben);
  assign is_cmp  = (r_subclass == SCLASS_EQU_MP) || (r_subclass == SCLASS_LTU_MP) ||
                   (r_subclass == SCLASS_GTU_MP);

`ifdef SCARV_COP_MALU_ISSUE_WATCHDOG_EN
  localparam int unsigned WDOG_W = $clog2(WDOG_LIMIT + 1);
  logic [WDOG_W-1:0] wdog;

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      wdog <= '0;
    end else if (accept) begin
      wdog <= '0;
    end else if (busy && !malu_idone) begin
      wdog <= wdog + 1'b1;
    end
  end

  // Abort in the cycle whose increment would make the count reach the limit.
  assign wdog_abort = busy && !malu_idone && (wdog == WDOG_W'(WDOG_LIMIT - 1));
`else
  assign wdog_abort = 1'b0;
`endif

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (id_valid) state_nxt = BUSY;
      BUSY: begin
        if (malu_idone)      state_nxt = RESP;
        else if (wdog_abort) state_nxt = IDLE;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    id_ready    = (state == IDLE);
    malu_ivalid = busy;
    insn_done   = (state == RESP);
    insn_err    = wdog_abort;
    gpr_wen     = (state == RESP) && gpr_flag;
    cpr_ra1     = '0;
    cpr_ra2     = '0;
    cpr_ra3     = '0;
    malu_rs1    = '0;
    malu_rs2    = '0;
    malu_rs3    = '0;
    cpr_wen     = wb_fire;
    cpr_waddr   = '0;
    cpr_wben    = '0;
    cpr_wdata   = '0;
    if (busy) begin
      cpr_ra1   = r_crs1;
      cpr_ra2   = malu_rdm_in_rs ? {r_crdm, 1'b1} : r_crs2;
      cpr_ra3   = malu_rdm_in_rs ? {r_crdm, 1'b0} : r_crs3;
      malu_rs1  = cpr_rd1;
      malu_rs2  = cpr_rd2;
      malu_rs3  = cpr_rd3;
      cpr_waddr = {r_crdm, wb_cnt};
      cpr_wben  = malu_cpr_rd_ben;
      cpr_wdata = malu_cpr_rd_wdata;
    end
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      r_subclass  <= '0;
      r_class     <= '0;
      r_imm       <= '0;
      r_crs1      <= '0;
      r_crs2      <= '0;
      r_crs3      <= '0;
      r_crdm      <= '0;
      r_gpr_rs1   <= '0;
      wb_cnt      <= 1'b0;
      gpr_flag    <= 1'b0;
      r_gpr_wdata <= '0;
    end else begin
      if (accept) begin
        r_subclass <= id_subclass;
        r_class    <= id_class;
        r_imm      <= id_imm;
        r_crs1     <= id_crs1;
        r_crs2     <= id_crs2;
        r_crs3     <= id_crs3;
        r_crdm     <= id_crdm;
        r_gpr_rs1  <= id_gpr_rs1;
        wb_cnt     <= 1'b0;
      end
      if (wb_fire) begin
        wb_cnt <= ~wb_cnt;
      end
      if (busy && malu_idone && is_cmp) begin
        r_gpr_wdata <= {31'b0, malu_cpr_rd_wdata[0]};
        gpr_flag    <= 1'b1;
      end
      if (state == RESP) begin
        gpr_flag <= 1'b0;
      end
    end
  end

  assign malu_gpr_rs1  = r_gpr_rs1;
  assign malu_imm      = r_imm;
  assign malu_class    = r_class;
  assign malu_subclass = r_subclass;
  assign gpr_wdata     = r_gpr_wdata;

endmodule

// File: tb/tb_scarv_cop_malu_issue.sv
// Bench for scarv_cop_malu_issue: the bench owns the CPR file and a MALU stand-in,
// and predicts every address, operand and writeback from the instruction fields.
module tb_scarv_cop_malu_issue;

  logic        g_clk, g_resetn;
  logic        id_valid, id_ready;
  logic [2:0]  id_class;
  logic [3:0]  id_subclass;
  logic [31:0] id_imm, id_gpr_rs1;
  logic [3:0]  id_crs1, id_crs2, id_crs3;
  logic [2:0]  id_crdm;
  logic [3:0]  cpr_ra1, cpr_ra2, cpr_ra3;
  logic [31:0] cpr_rd1, cpr_rd2, cpr_rd3;
  logic        malu_ivalid, malu_idone, malu_rdm_in_rs;
  logic [31:0] malu_rs1, malu_rs2, malu_rs3, malu_gpr_rs1, malu_imm;
  logic [2:0]  malu_class;
  logic [3:0]  malu_subclass, malu_cpr_rd_ben, cpr_wben;
  logic [31:0] malu_cpr_rd_wdata, cpr_wdata, gpr_wdata;
  logic        cpr_wen, gpr_wen, insn_done, insn_err;
  logic [3:0]  cpr_waddr;

  logic [31:0] cpr_mem [16];

  int n_checks = 0;
  int n_fail   = 0;

  int unsigned cur_sc, cur_cls, cur_c1, cur_c2, cur_c3, cur_dm;
  logic [31:0] cur_rs1, cur_imm;
  int unsigned wbk;
  logic        exp_flag;
  logic [31:0] exp_gwd;

  scarv_cop_malu_issue #(.CPR_AW(4), .WDOG_LIMIT(7)) dut (
    .g_clk(g_clk), .g_resetn(g_resetn),
    .id_valid(id_valid), .id_ready(id_ready), .id_class(id_class), .id_subclass(id_subclass),
    .id_imm(id_imm), .id_crs1(id_crs1), .id_crs2(id_crs2), .id_crs3(id_crs3),
    .id_crdm(id_crdm), .id_gpr_rs1(id_gpr_rs1),
    .cpr_ra1(cpr_ra1), .cpr_ra2(cpr_ra2), .cpr_ra3(cpr_ra3),
    .cpr_rd1(cpr_rd1), .cpr_rd2(cpr_rd2), .cpr_rd3(cpr_rd3),
    .malu_ivalid(malu_ivalid), .malu_idone(malu_idone), .malu_rdm_in_rs(malu_rdm_in_rs),
    .malu_rs1(malu_rs1), .malu_rs2(malu_rs2), .malu_rs3(malu_rs3),
    .malu_gpr_rs1(malu_gpr_rs1), .malu_imm(malu_imm), .malu_class(malu_class),
    .malu_subclass(malu_subclass), .malu_cpr_rd_ben(malu_cpr_rd_ben),
    .malu_cpr_rd_wdata(malu_cpr_rd_wdata), .cpr_wen(cpr_wen), .cpr_waddr(cpr_waddr),
    .cpr_wben(cpr_wben), .cpr_wdata(cpr_wdata), .gpr_wen(gpr_wen), .gpr_wdata(gpr_wdata),
    .insn_done(insn_done), .insn_err(insn_err)
  );

  assign cpr_rd1 = cpr_mem[cpr_ra1];
  assign cpr_rd2 = cpr_mem[cpr_ra2];
  assign cpr_rd3 = cpr_mem[cpr_ra3];

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit cmp_class(input int unsigned sc);
    return (sc >= 1) && (sc <= 3);
  endfunction

  task automatic set_fields(input int unsigned sc, input int unsigned cls, input int unsigned c1,
                            input int unsigned c2, input int unsigned c3, input int unsigned dm,
                            input logic [31:0] rs1, input logic [31:0] imm);
    id_subclass = 4'(sc); id_class = 3'(cls);
    id_crs1 = 4'(c1); id_crs2 = 4'(c2); id_crs3 = 4'(c3); id_crdm = 3'(dm);
    id_gpr_rs1 = rs1; id_imm = imm;
  endtask

  // Present an instruction in an IDLE cycle; it is accepted on the next rising edge.
  task automatic issue(input int unsigned sc, input int unsigned cls, input int unsigned c1,
                       input int unsigned c2, input int unsigned c3, input int unsigned dm,
                       input logic [31:0] rs1, input logic [31:0] imm, input bit keep_valid);
    @(negedge g_clk);
    set_fields(sc, cls, c1, c2, c3, dm, rs1, imm);
    id_valid = 1'b1;
    cur_sc = sc; cur_cls = cls; cur_c1 = c1; cur_c2 = c2; cur_c3 = c3; cur_dm = dm;
    cur_rs1 = rs1; cur_imm = imm; wbk = 0;
    #1;
    chk("idle_ready", 32'(id_ready), 32'd1);
    @(posedge g_clk);
    #1;
    if (!keep_valid) id_valid = 1'b0;
  endtask

  // One BUSY cycle: drive the MALU side, check routing, then commit to the CPR model.
  task automatic beat(input logic [3:0] ben, input logic [31:0] wd, input logic done,
                      input logic rdm);
    int unsigned a2, a3, aw;
    @(negedge g_clk);
    malu_cpr_rd_ben = ben; malu_cpr_rd_wdata = wd; malu_idone = done; malu_rdm_in_rs = rdm;
    #1;
    a2 = rdm ? cur_dm * 2 + 1 : cur_c2;
    a3 = rdm ? cur_dm * 2     : cur_c3;
    aw = cur_dm * 2 + wbk;
    chk("busy_ivalid", 32'(malu_ivalid), 32'd1);
    chk("busy_ready", 32'(id_ready), 32'd0);
    chk("busy_done", 32'(insn_done), 32'd0);
    chk("busy_err", 32'(insn_err), 32'd0);
    chk("ra1", 32'(cpr_ra1), 32'(cur_c1));
    chk("ra2", 32'(cpr_ra2), 32'(a2));
    chk("ra3", 32'(cpr_ra3), 32'(a3));
    chk("rs1", malu_rs1, cpr_mem[cur_c1]);
    chk("rs2", malu_rs2, cpr_mem[a2]);
    chk("rs3", malu_rs3, cpr_mem[a3]);
    chk("lat_subclass", 32'(malu_subclass), 32'(cur_sc));
    chk("lat_class", 32'(malu_class), 32'(cur_cls));
    chk("lat_imm", malu_imm, cur_imm);
    chk("lat_gpr_rs1", malu_gpr_rs1, cur_rs1);
    chk("cpr_wen", 32'(cpr_wen), 32'(ben != 4'd0));
    if (ben != 4'd0) begin
      chk("cpr_waddr", 32'(cpr_waddr), 32'(aw));
      chk("cpr_wben", 32'(cpr_wben), 32'(ben));
      chk("cpr_wdata", cpr_wdata, wd);
    end
    @(posedge g_clk);
    #1;
    if (ben != 4'd0) begin
      for (int unsigned b = 0; b < 4; b++)
        if (ben[b]) cpr_mem[aw][8*b +: 8] = wd[8*b +: 8];
      wbk = (wbk + 1) % 2;
    end
    if (done && cmp_class(cur_sc)) begin
      exp_flag = 1'b1;
      exp_gwd  = {31'b0, wd[0]};
    end
  endtask

  task automatic resp_chk(input bit check_idle);
    @(negedge g_clk);
    malu_cpr_rd_ben = 4'd0; malu_idone = 1'b0; malu_rdm_in_rs = 1'b0;
    #1;
    chk("resp_done", 32'(insn_done), 32'd1);
    chk("resp_ivalid", 32'(malu_ivalid), 32'd0);
    chk("resp_ready", 32'(id_ready), 32'd0);
    chk("resp_cpr_wen", 32'(cpr_wen), 32'd0);
    chk("resp_gpr_wen", 32'(gpr_wen), 32'(exp_flag));
    chk("resp_gpr_wdata", gpr_wdata, exp_gwd);
    exp_flag = 1'b0;
    if (check_idle) begin
      @(negedge g_clk);
      #1;
      chk("after_done", 32'(insn_done), 32'd0);
      chk("after_gpr_wen", 32'(gpr_wen), 32'd0);
      chk("after_ready", 32'(id_ready), 32'd1);
    end
  endtask

  logic [63:0] acc;
  int unsigned nb, sc;
  logic [3:0]  rben;

  initial begin
    g_resetn = 1'b0; id_valid = 1'b0; malu_idone = 1'b0; malu_rdm_in_rs = 1'b0;
    malu_cpr_rd_ben = 4'd0; malu_cpr_rd_wdata = '0;
    set_fields(0, 0, 0, 0, 0, 0, '0, '0);
    exp_flag = 1'b0; exp_gwd = '0;
    for (int i = 0; i < 16; i++) cpr_mem[i] = $urandom;
    #1;
    chk("rst_ready", 32'(id_ready), 32'd1);
    chk("rst_ivalid", 32'(malu_ivalid), 32'd0);
    chk("rst_cpr_wen", 32'(cpr_wen), 32'd0);
    chk("rst_gpr_wen", 32'(gpr_wen), 32'd0);
    chk("rst_done", 32'(insn_done), 32'd0);
    chk("rst_err", 32'(insn_err), 32'd0);
    chk("rst_gpr_wdata", gpr_wdata, 32'd0);
    chk("rst_imm", malu_imm, 32'd0);
    chk("rst_waddr", 32'(cpr_waddr), 32'd0);
    @(negedge g_clk);
    g_resetn = 1'b1;

    // ADD2: 0xFFFFFFFF + 1 lands as lo=0, hi=1 in pair 2.
    cpr_mem[2] = 32'hFFFF_FFFF; cpr_mem[3] = 32'h1;
    issue(5, 3, 2, 3, 0, 2, 32'h1234, 32'h55, 0);
    acc = {32'b0, cpr_mem[2]} + {32'b0, cpr_mem[3]};
    beat(4'hF, acc[31:0], 1'b0, 1'b0);
    beat(4'hF, acc[63:32], 1'b1, 1'b0);
    resp_chk(1);

    // ACC1: rdm pair 3 is read through rs2/rs3 and accumulated into.
    issue(13, 3, 9, 1, 1, 3, 32'h0, 32'h0, 0);
    acc = {cpr_mem[7], cpr_mem[6]} + {32'b0, cpr_mem[9]};
    beat(4'hF, acc[31:0], 1'b0, 1'b1);
    beat(4'hF, acc[63:32], 1'b1, 1'b1);
    resp_chk(1);

    // LTU: result returns as a GPR write, no CPR write.
    issue(2, 3, 4, 5, 0, 1, 32'h0, 32'h0, 0);
    beat(4'h0, 32'h0, 1'b0, 1'b0);
    beat(4'h0, 32'h1, 1'b1, 1'b0);
    resp_chk(1);

    // Back-to-back with id_valid held; decode fields change under the first instruction.
    issue(6, 1, 1, 2, 3, 4, 32'hAAAA_0001, 32'h11, 1);
    set_fields(3, 2, 7, 8, 9, 5, 32'hBBBB_0002, 32'h22);
    beat(4'h3, 32'hCAFE_F00D, 1'b0, 1'b0);
    beat(4'hC, 32'hDEAD_BEEF, 1'b1, 1'b0);
    resp_chk(0);
    issue(3, 2, 7, 8, 9, 5, 32'hBBBB_0002, 32'h22, 0);
    beat(4'h0, 32'h0, 1'b1, 1'b0);
    resp_chk(1);

    // Randomized instruction stream.
    for (int n = 0; n < 40; n++) begin
      sc = $urandom_range(15, 0);
      issue(sc, $urandom_range(7, 0), $urandom_range(15, 0), $urandom_range(15, 0),
            $urandom_range(15, 0), $urandom_range(7, 0), $urandom, $urandom, 0);
      nb = $urandom_range(4, 1);
      for (int unsigned k = 1; k <= nb; k++) begin
        rben = cmp_class(sc) ? 4'd0 : 4'($urandom_range(15, 0));
        beat(rben, $urandom, 1'(k == nb), 1'($urandom_range(1, 0)));
      end
      resp_chk(1);
    end

    // Asynchronous reset after one write of a pair.
    issue(5, 3, 1, 2, 0, 6, 32'h0, 32'h0, 0);
    beat(4'hF, 32'h0123_4567, 1'b0, 1'b0);
    @(negedge g_clk);
    malu_cpr_rd_ben = 4'hF; malu_cpr_rd_wdata = 32'h89AB_CDEF;
    #2;
    g_resetn = 1'b0;
    #1;
    chk("arst_ivalid", 32'(malu_ivalid), 32'd0);
    chk("arst_ready", 32'(id_ready), 32'd1);
    chk("arst_cpr_wen", 32'(cpr_wen), 32'd0);
    chk("arst_class", 32'(malu_class), 32'd0);
    exp_gwd = '0;
    @(negedge g_clk);
    g_resetn = 1'b1;
    #1;
    chk("arst_idle_wen", 32'(cpr_wen), 32'd0);
    chk("arst_gpr_wdata", gpr_wdata, 32'd0);
    malu_cpr_rd_ben = 4'd0;

    // MALU never completes.
    issue(4, 3, 1, 2, 3, 0, 32'h0, 32'h0, 0);
    for (int c = 1; c <= 20; c++) begin
      @(negedge g_clk);
      #1;
`ifdef SCARV_COP_MALU_ISSUE_WATCHDOG_EN
      chk("wdog_err", 32'(insn_err), 32'(c == 7));
      chk("wdog_ivalid", 32'(malu_ivalid), 32'd1);
      if (c == 7) break;
`else
      chk("hang_err", 32'(insn_err), 32'd0);
      if (c == 20) chk("hang_ivalid", 32'(malu_ivalid), 32'd1);
`endif
    end
`ifdef SCARV_COP_MALU_ISSUE_WATCHDOG_EN
    @(negedge g_clk);
    #1;
    chk("wdog_idle_ready", 32'(id_ready), 32'd1);
    chk("wdog_idle_ivalid", 32'(malu_ivalid), 32'd0);
    chk("wdog_no_done", 32'(insn_done), 32'd0);
    chk("wdog_no_gpr", 32'(gpr_wen), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
